// File: rtl/store_unit_pkg.sv
// Shared store-path definitions: funct3 encodings, bus widths and the
// store-buffer entry layout.
package store_unit_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int REG_W      = 32;
  localparam int MEM_W      = 32;
  localparam int STRB_W     = 4;

  localparam logic [6:0] INST_TYPE_S = 7'b0100011;
  localparam logic [2:0] INST_SB     = 3'b000;
  localparam logic [2:0] INST_SH     = 3'b001;
  localparam logic [2:0] INST_SW     = 3'b010;

  typedef struct packed {
    logic [MEM_ADDR_W-3:0] waddr;
    logic [MEM_W-1:0]      wdata;
    logic [STRB_W-1:0]     wstrb;
  } st_entry_t;

endpackage

// File: rtl/store_unit_fmt.sv
// Combinational store formatter: replicates rs2 across lanes and derives the
// byte strobes plus misaligned/illegal flags from funct3 and the low address bits.
module store_fmt
  import store_unit_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [REG_W-1:0]  data_i,
  output logic [MEM_W-1:0]  wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              misaligned_o,
  output logic              illegal_o
);

  always_comb begin
    wdata_o      = '0;
    wstrb_o      = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      INST_SB: begin
        wdata_o = {4{data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      INST_SH: begin
        wdata_o      = {2{data_i[15:0]}};
        wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misaligned_o = addr_lo_i[0];
      end
      INST_SW: begin
        wdata_o      = data_i;
        wstrb_o      = 4'b1111;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store buffer: formats SB/SH/SW requests, queues them in a strict FIFO and
// drains them to the data RAM over req/ack; flags loads hitting a pending word.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [2:0]            st_funct3_i,
  input  logic [MEM_ADDR_W-1:0] st_addr_i,
  input  logic [REG_W-1:0]      st_data_i,
  output logic                  err_o,
  output logic [MEM_ADDR_W-1:0] err_addr_o,
  output logic                  ram_req_o,
  output logic [MEM_ADDR_W-1:0] ram_addr_o,
  output logic [MEM_W-1:0]      ram_wdata_o,
  output logic [STRB_W-1:0]     ram_wstrb_o,
  input  logic                  ram_ack_i,
  input  logic [MEM_ADDR_W-1:0] ld_chk_addr_i,
  output logic                  ld_hit_o,
  output logic                  empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [MEM_W-1:0]      fmt_wdata;
  logic [STRB_W-1:0]     fmt_wstrb;
  logic                  fmt_mis;
  logic                  fmt_ill;

  logic                  accept, push, pop, reject;
  logic [CNT_W-1:0]      count_d, count_q;
  logic [PTR_W-1:0]      wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [DEPTH-1:0]      vld_d, vld_q;
  logic                  err_d, err_q;
  logic [MEM_ADDR_W-1:0] err_addr_d, err_addr_q;
  st_entry_t             buf_d [DEPTH];
  st_entry_t             buf_q [DEPTH];
  logic                  unused_ld_lo;

  store_fmt u_fmt (
    .funct3_i     (st_funct3_i),
    .addr_lo_i    (st_addr_i[1:0]),
    .data_i       (st_data_i),
    .wdata_o      (fmt_wdata),
    .wstrb_o      (fmt_wstrb),
    .misaligned_o (fmt_mis),
    .illegal_o    (fmt_ill)
  );

  assign st_ready_o  = (count_q != CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign ram_req_o   = !empty_o;
  assign ram_addr_o  = {buf_q[rd_ptr_q].waddr, 2'b00};
  assign ram_wdata_o = buf_q[rd_ptr_q].wdata;
  assign ram_wstrb_o = buf_q[rd_ptr_q].wstrb;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign unused_ld_lo = ^ld_chk_addr_i[1:0];

  // Rejected stores are consumed from the pipeline but never reach the FIFO.
  assign accept = st_valid_i && st_ready_o;
  assign reject = accept && (fmt_mis || fmt_ill);
  assign push   = accept && !(fmt_mis || fmt_ill);
  assign pop    = ram_req_o && ram_ack_i;

  always_comb begin
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    err_d      = reject;
    err_addr_d = reject ? st_addr_i : err_addr_q;
    vld_d      = vld_q;
    buf_d      = buf_q;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      buf_d[wr_ptr_q] = '{waddr: st_addr_i[MEM_ADDR_W-1:2], wdata: fmt_wdata, wstrb: fmt_wstrb};
    end
  end

  // Only registered entries are compared; an in-flight accept cannot hit.
  always_comb begin
    ld_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (buf_q[i].waddr == ld_chk_addr_i[MEM_ADDR_W-1:2])) ld_hit_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule
